// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_e;

  function automatic logic [INST_W-1:0] pc_plus4(input logic [INST_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [INST_W-1:0] next_inst,
  input  logic [INST_W-1:0] next_pc,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] pc,
  output logic              valid
);

  logic [INST_W-1:0] inst_r;
  logic [INST_W-1:0] pc_r;
  logic              valid_r;

  // Load has priority over bubble; a bubble keeps the last PC value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r  <= NOP_INST;
      pc_r    <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (load) begin
      inst_r  <= next_inst;
      pc_r    <= next_pc;
      valid_r <= 1'b1;
    end else if (bubble) begin
      inst_r  <= NOP_INST;
      pc_r    <= pc_r;
      valid_r <= 1'b0;
    end else begin
      inst_r  <= inst_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end
  end

  assign inst  = inst_r;
  assign pc    = pc_r;
  assign valid = valid_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM over a req/ack instruction memory,
// stall freeze and branch redirect feeding the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hazard_i,
  input  logic              branch_i,
  input  logic [INST_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [INST_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] IF_ID_inst_o,
  output logic [INST_W-1:0] IF_ID_pc_o,
  output logic              IF_ID_valid_o
);

  fetch_state_e      state_r, next_state_s;
  logic [INST_W-1:0] pc_r, pc_next_s, pc_inc_s;
  logic [INST_W-1:0] hold_r, redirect_r;
  logic              req_r;
  logic              hold_load_s, redirect_load_s;
  logic              id_load_s, id_bubble_s;
  logic [INST_W-1:0] id_inst_s;

  assign pc_inc_s = pc_plus4(pc_r);

  // Next-state, PC and IF/ID control; hazard always wins over branch.
  always_comb begin
    next_state_s    = state_r;
    pc_next_s       = pc_r;
    hold_load_s     = 1'b0;
    redirect_load_s = 1'b0;
    id_load_s       = 1'b0;
    id_bubble_s     = 1'b0;
    id_inst_s       = imem_data_i;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          if (hazard_i) begin
            hold_load_s  = 1'b1;
            next_state_s = ST_HOLD;
          end else if (branch_i) begin
            pc_next_s   = branch_target_i;
            id_bubble_s = 1'b1;
          end else begin
            id_load_s = 1'b1;
            pc_next_s = pc_inc_s;
          end
        end else if (hazard_i) begin
          next_state_s = ST_FETCH;
        end else if (branch_i) begin
          // Address must not move under an outstanding request.
          redirect_load_s = 1'b1;
          id_bubble_s     = 1'b1;
          next_state_s    = ST_KILL;
        end else begin
          id_bubble_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hazard_i) begin
          next_state_s = ST_HOLD;
        end else if (branch_i) begin
          pc_next_s    = branch_target_i;
          id_bubble_s  = 1'b1;
          next_state_s = ST_FETCH;
        end else begin
          id_load_s    = 1'b1;
          id_inst_s    = hold_r;
          pc_next_s    = pc_inc_s;
          next_state_s = ST_FETCH;
        end
      end
      ST_KILL: begin
        id_bubble_s = 1'b1;
        if (branch_i && !hazard_i) begin
          redirect_load_s = 1'b1;
        end else begin
          redirect_load_s = 1'b0;
        end
        if (imem_ack_i) begin
          pc_next_s    = redirect_load_s ? branch_target_i : redirect_r;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_KILL;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        pc_next_s    = RESET_PC;
      end
    endcase
  end

  // FSM, PC, hold and redirect registers; req is registered from next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      hold_r     <= 32'h0000_0000;
      redirect_r <= 32'h0000_0000;
      req_r      <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pc_r       <= pc_next_s;
      hold_r     <= hold_load_s ? imem_data_i : hold_r;
      redirect_r <= redirect_load_s ? branch_target_i : redirect_r;
      req_r      <= (next_state_s == ST_FETCH) || (next_state_s == ST_KILL);
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = pc_r;

  if_fetch_stage_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .load      (id_load_s),
    .bubble    (id_bubble_s),
    .next_inst (id_inst_s),
    .next_pc   (pc_inc_s),
    .inst      (IF_ID_inst_o),
    .pc        (IF_ID_pc_o),
    .valid     (IF_ID_valid_o)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns word = address.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, hazard_i, branch_i, imem_ack_i;
  logic [31:0] branch_target_i, imem_data_i;
  logic        imem_req_o, IF_ID_valid_o;
  logic [31:0] imem_addr_o, IF_ID_inst_o, IF_ID_pc_o;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .hazard_i        (hazard_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .IF_ID_inst_o    (IF_ID_inst_o),
    .IF_ID_pc_o      (IF_ID_pc_o),
    .IF_ID_valid_o   (IF_ID_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check req/addr before the edge, push expected IF/ID, pop after.
  task automatic cycle(input string tag, input logic ack, input logic haz, input logic br,
                       input logic [31:0] tgt, input logic exp_req, input logic [31:0] exp_addr,
                       input logic exp_valid, input logic [31:0] exp_inst, input logic [31:0] exp_pc);
    exp_t e;
    chk({tag, "/req"}, {31'd0, imem_req_o}, {31'd0, exp_req});
    chk({tag, "/addr"}, imem_addr_o, exp_addr);
    imem_ack_i      = ack;
    hazard_i        = haz;
    branch_i        = br;
    branch_target_i = tgt;
    imem_data_i     = imem_addr_o;
    sb.push_back('{valid: exp_valid, inst: exp_inst, pc: exp_pc});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk({tag, "/valid"}, {31'd0, IF_ID_valid_o}, {31'd0, e.valid});
    chk({tag, "/inst"}, IF_ID_inst_o, e.inst);
    if (e.valid) chk({tag, "/idpc"}, IF_ID_pc_o, e.pc);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; hazard_i = 1'b0; branch_i = 1'b0;
    branch_target_i = 32'h0; imem_ack_i = 1'b0; imem_data_i = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("rst/req", {31'd0, imem_req_o}, 32'd0);
    chk("rst/addr", imem_addr_o, 32'h0);
    chk("rst/valid", {31'd0, IF_ID_valid_o}, 32'd0);
    chk("rst/inst", IF_ID_inst_o, NOP);
    chk("rst/idpc", IF_ID_pc_o, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // zero-wait streaming
    start_i = 1'b1;
    cycle("start", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, NOP,     32'h0);
    cycle("s0",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b1, 32'h00,  32'h04);
    cycle("s4",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1, 32'h04,  32'h08);
    cycle("s8",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h08,  32'h0C);
    cycle("sC",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h0C,  32'h10);
    // two-cycle ack delay at 0x10
    cycle("w1",    1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, NOP,     32'h0);
    cycle("w2",    1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, NOP,     32'h0);
    cycle("w3",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h10,  32'h14);
    cycle("s14",   1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'h14,  32'h18);
    cycle("s18",   1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1, 32'h18,  32'h1C);
    cycle("s1C",   1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C, 1'b1, 32'h1C,  32'h20);
    // stall with ack at 0x20
    cycle("h1",    1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h1C,  32'h20);
    cycle("h2",    1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, 1'b1, 32'h1C,  32'h20);
    cycle("hrel",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h20, 1'b1, 32'h20,  32'h24);
    cycle("s24",   1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 1'b1, 32'h24,  32'h28);
    // branch with ack
    cycle("bra",   1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h28, 1'b0, NOP,   32'h0);
    cycle("s100",  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h100, 32'h104);
    // branch during outstanding request
    cycle("k0",    1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h104, 1'b0, NOP,  32'h0);
    cycle("k1",    1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, NOP,    32'h0);
    cycle("k2",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, NOP,    32'h0);
    cycle("s200",  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h200, 32'h204);
    // hazard beats branch
    cycle("hb",    1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h204, 1'b1, 32'h200, 32'h204);
    cycle("s204",  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 32'h204, 32'h208);
    // second branch in KILL overwrites redirect
    cycle("ko0",   1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h208, 1'b0, NOP,  32'h0);
    cycle("ko1",   1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h208, 1'b0, NOP,  32'h0);
    cycle("ko2",   1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h208, 1'b0, NOP,    32'h0);
    cycle("s500",  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 32'h500, 32'h504);
    // PC wrap
    cycle("bwr",   1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h504, 1'b0, NOP, 32'h0);
    cycle("sFFC",  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0);
    cycle("swr0",  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0,    32'h4);
    // branch out of HOLD
    cycle("hb1",   1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0,    32'h4);
    cycle("hb2",   1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h4, 1'b0, NOP,     32'h0);
    cycle("s40",   1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h40,  32'h44);
    // reset mid-KILL
    cycle("rk0",   1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h44, 1'b0, NOP,   32'h0);
    cycle("rk1",   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0, NOP,     32'h0);
    chk("prerst/idpc", IF_ID_pc_o, 32'h44);
    start_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    chk("arst/req", {31'd0, imem_req_o}, 32'd0);
    chk("arst/addr", imem_addr_o, 32'h0);
    chk("arst/valid", {31'd0, IF_ID_valid_o}, 32'd0);
    chk("arst/inst", IF_ID_inst_o, NOP);
    chk("arst/idpc", IF_ID_pc_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle("idle1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP,      32'h0);
    cycle("idle2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP,      32'h0);
    start_i = 1'b1;
    cycle("rst2",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP,      32'h0);
    cycle("r0",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0,    32'h4);
    // start falling has no effect
    start_i = 1'b0;
    cycle("r4",    1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h4,    32'h8);
    cycle("r8w",   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, NOP,      32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
